// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, pointer code conversions and
// the write-side flag bundle. Used by both the write and read controllers.
package fifo_pkg;

  localparam int ADDR_W_DEF    = 3;
  localparam int AF_MARGIN_DEF = 2;

  // Widest pointer the helpers handle; callers cast to their own width.
  localparam int PTR_MAX_W = 32;

  // Next-state flag bundle computed once per cycle by a controller.
  typedef struct packed {
    logic full;
    logic almost_full;
    logic ovf;
  } fifo_wflags_t;

  // Reflected binary code of a binary count.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Parametrised combinational Gray-to-binary converter (XOR prefix from MSB).
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Bit i is the reduction XOR of gray[W-1:i]; no chained dependency.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: binary/Gray write pointer,
// full / almost-full / occupancy flags against the synchronised read
// pointer, and a sticky overflow flag. The read pointer arrives already
// synchronised, so this block holds no synchroniser flops.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_MARGIN = AF_MARGIN_DEF   // legal 1..DEPTH-1
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              winc,
  input  logic [ADDR_W:0]   wg2_rptr,
  input  logic              wovf_clr,
  output logic [ADDR_W:0]   wptr,
  output logic [ADDR_W-1:0] waddr,
  output logic              wen,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              wovf
);

  localparam int                 PTR_W  = ADDR_W + 1;
  localparam int                 DEPTH  = 1 << ADDR_W;
  localparam logic [PTR_W-1:0]   AF_THR = PTR_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rgray_full;
  logic [PTR_W-1:0] level_next;
  fifo_wflags_t     flags_next;

  // A write is accepted only while not full; overflowing requests are dropped.
  assign wen       = winc & ~wfull;
  assign wbin_next = wbin + PTR_W'(wen);
  assign wgray_next = PTR_W'(bin2gray(PTR_MAX_W'(wbin_next)));
  assign waddr     = wbin[ADDR_W-1:0];

  // Read pointer as it would look if the writer were exactly one lap ahead.
  if (ADDR_W == 1) begin : g_full_aw1
    assign rgray_full = ~wg2_rptr;
  end else begin : g_full_awn
    assign rgray_full = {~wg2_rptr[ADDR_W:ADDR_W-1], wg2_rptr[ADDR_W-2:0]};
  end

  fifo_gray2bin #(.W(PTR_W)) u_g2b (
    .gray (wg2_rptr),
    .bin  (rbin)
  );

  // Occupancy wraps naturally modulo 2**PTR_W, giving 0..DEPTH.
  assign level_next = wbin_next - rbin;

  // Next-state flags; overflow set takes priority over a simultaneous clear.
  always_comb begin
    flags_next             = '0;
    flags_next.full        = (wgray_next == rgray_full);
    flags_next.almost_full = (level_next >= AF_THR);
    flags_next.ovf         = (winc & wfull) | (wovf & ~wovf_clr);
  end

  // Binary and Gray pointers advance together so wptr never lags wbin.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin <= '0;
      wptr <= '0;
    end else begin
      wbin <= wbin_next;
      wptr <= wgray_next;
    end
  end

  // Registered status flags and occupancy.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wfull        <= flags_next.full;
      walmost_full <= flags_next.almost_full;
      wlevel       <= level_next;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) wovf <= 1'b0;
    else         wovf <= flags_next.ovf;
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl. The model tracks total accepted writes
// and total reads as plain integers; occupancy is their difference.
module tb_fifo_wr_ctrl;

  localparam int D  = 8;
  localparam int AF = 2;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic       wovf_clr = 1'b0;
  logic [3:0] wg2_rptr = '0;
  logic [3:0] wptr, wlevel;
  logic [2:0] waddr;
  logic       wen, wfull, walmost_full, wovf;

  // Parameter-sweep instances share reset, driven only by sw_winc.
  logic       sw_winc = 1'b0;
  logic [1:0] s1_wptr, s1_wlevel;
  logic [0:0] s1_waddr;
  logic       s1_wen, s1_wfull, s1_waf, s1_wovf;
  logic [5:0] s5_wptr, s5_wlevel;
  logic [4:0] s5_waddr;
  logic       s5_wen, s5_wfull, s5_waf, s5_wovf;

  always #5 wclk = ~wclk;

  fifo_wr_ctrl #(.ADDR_W(3), .AF_MARGIN(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wg2_rptr(wg2_rptr),
    .wovf_clr(wovf_clr), .wptr(wptr), .waddr(waddr), .wen(wen),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf)
  );

  fifo_wr_ctrl #(.ADDR_W(1), .AF_MARGIN(1)) dut_s1 (
    .wclk(wclk), .wrst_n(wrst_n), .winc(sw_winc), .wg2_rptr(2'b00),
    .wovf_clr(1'b0), .wptr(s1_wptr), .waddr(s1_waddr), .wen(s1_wen),
    .wfull(s1_wfull), .walmost_full(s1_waf), .wlevel(s1_wlevel), .wovf(s1_wovf)
  );

  fifo_wr_ctrl #(.ADDR_W(5), .AF_MARGIN(1)) dut_s5 (
    .wclk(wclk), .wrst_n(wrst_n), .winc(sw_winc), .wg2_rptr(6'b000000),
    .wovf_clr(1'b0), .wptr(s5_wptr), .waddr(s5_waddr), .wen(s5_wen),
    .wfull(s5_wfull), .walmost_full(s5_waf), .wlevel(s5_wlevel), .wovf(s5_wovf)
  );

  typedef struct {
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       wen;
    logic       wfull;
    logic       waf;
    logic [3:0] wlevel;
    logic       wovf;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: expected register contents after the last edge.
  int   wcnt, rcnt, m_level;
  bit   m_full, m_af, m_ovf;

  function automatic logic [3:0] gray4(input int x);
    logic [3:0] b;
    b = 4'(x % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wcnt = 0; rcnt = 0; m_level = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  // Drive one cycle of inputs; push what the DUT must show during it.
  task automatic step(input bit inc, input int rd, input bit clr);
    exp_t e;
    int   occ;
    @(posedge wclk); #1;
    winc = inc; wovf_clr = clr; rcnt = rd; wg2_rptr = gray4(rd);
    e.wptr = gray4(wcnt); e.waddr = 3'(wcnt % D);
    e.wen = inc && !m_full; e.wfull = m_full; e.waf = m_af;
    e.wlevel = 4'(m_level); e.wovf = m_ovf;
    q.push_back(e);
    if (inc && m_full) m_ovf = 1; else if (clr) m_ovf = 0;
    if (inc && !m_full) wcnt++;
    occ = wcnt - rcnt;
    m_level = occ;
    m_full = (occ == D);
    m_af = (occ >= D - AF);
  endtask

  // Monitor: compares whatever the scoreboard expects for this cycle.
  always @(negedge wclk) begin : mon
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("wptr",   wptr,         e.wptr);
      check("waddr",  waddr,        e.waddr);
      check("wen",    wen,          e.wen);
      check("wfull",  wfull,        e.wfull);
      check("waf",    walmost_full, e.waf);
      check("wlevel", wlevel,       e.wlevel);
      check("wovf",   wovf,         e.wovf);
    end
  end

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : stim
    int r;
    model_reset();
    #23 wrst_n = 1'b1;

    // A few writes, then reset lands mid-burst.
    repeat (4) step(1, 0, 0);
    @(negedge wclk); #1;
    wrst_n = 1'b0;
    #1;
    check("rst_wptr",   wptr, 4'h0);
    check("rst_waddr",  waddr, 3'h0);
    check("rst_wen",    wen, 1'b1);
    check("rst_wfull",  wfull, 1'b0);
    check("rst_waf",    walmost_full, 1'b0);
    check("rst_wlevel", wlevel, 4'h0);
    check("rst_wovf",   wovf, 1'b0);
    @(posedge wclk); #2;
    check("rst_drop_wptr", wptr, 4'h0);
    winc = 1'b0; wg2_rptr = '0;
    @(negedge wclk); #1;
    wrst_n = 1'b1;
    model_reset();

    // Fill to full.
    repeat (8) step(1, 0, 0);
    // Overflow while full.
    step(1, 0, 0);
    check("fill_wptr",   wptr, 4'hC);
    check("fill_wfull",  wfull, 1'b1);
    check("fill_wlevel", wlevel, 4'h8);
    check("fill_wen",    wen, 1'b0);
    step(1, 0, 0);
    step(0, 0, 1);
    step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);

    // Reader catches up completely, then wrap through a second lap.
    step(0, 8, 0);
    repeat (8) step(1, 8, 0);
    step(0, 8, 0);
    step(0, 8, 0);

    // Partial drain, then steady write-and-read.
    step(0, 12, 0);
    repeat (20) step(1, rcnt + 1, 0);
    step(0, rcnt, 0);

    // Randomised traffic: write-heavy then read-heavy mix.
    for (int i = 0; i < 400; i++) begin
      r = (i < 200) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      if (rcnt + r > wcnt) r = wcnt - rcnt;
      step(($urandom % 4) != 0, rcnt + r, ($urandom % 8) == 0);
    end
    step(0, rcnt, 0);
    @(negedge wclk); #1;

    // Parameter sweep: depths 2 and 32 with almost-full margin 1.
    wrst_n = 1'b0; winc = 1'b0;
    @(negedge wclk); #1;
    wrst_n = 1'b1;
    sw_winc = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      int o1, o5;
      @(posedge wclk); #1;
      o1 = (i < 2) ? i : 2;
      o5 = (i < 32) ? i : 32;
      check("s1_wfull",  s1_wfull,  o1 == 2);
      check("s1_waf",    s1_waf,    o1 >= 1);
      check("s1_wlevel", s1_wlevel, o1);
      check("s5_wfull",  s5_wfull,  o5 == 32);
      check("s5_waf",    s5_waf,    o5 >= 31);
      check("s5_wlevel", s5_wlevel, o5);
    end
    sw_winc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
